// File: rtl/seq_stream_unpacker_if.sv
// FIFO-pop and slice-stream signals of the sequential-reader unpacker.
// The master side is the unpacker; the slave side is the FIFO plus the downstream consumer.
interface seq_stream_unpacker_if #(
  parameter int OUT_W = 32
) ();
  logic             rd_en;
  logic [127:0]     dout;
  logic             fifo_empty;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output rd_en, out_valid, out_data, out_last,
    input  dout, fifo_empty, out_ready
  );

  modport slave (
    input  rd_en, out_valid, out_data, out_last,
    output dout, fifo_empty, out_ready
  );
endinterface

// File: rtl/seq_stream_unpacker.sv
// Frame sequencer and 128-bit-to-OUT_W unpacker behind the DDR2 sequential reader's FIFO:
// rewind the reader, flush stale FIFO words, then stream one frame of slices LSB first.
module seq_stream_unpacker #(
  parameter int          OUT_W       = 32,
  parameter logic [31:0] FRAME_WORDS = 32'd65536,
  parameter logic [7:0]  BOTTOM_HOLD = 8'd8,
  parameter logic [7:0]  FLUSH_IDLE  = 8'd32
) (
  input  logic                  rd_clk,
  input  logic                  RST,
  input  logic                  frame_go,
  input  logic                  abort,
  output logic                  start,
  output logic                  bottom,
  output logic                  busy,
  output logic                  frame_done,
  seq_stream_unpacker_if.master bus
);

  localparam int NSL = 128 / OUT_W;
  localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [SW-1:0] TOP = SW'(NSL - 1);

  typedef enum logic [1:0] {S_IDLE, S_REWIND, S_FLUSH, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      idle_q, idle_d;
  logic [127:0]    ent0_q, ent0_d;
  logic [127:0]    ent1_q, ent1_d;
  logic [1:0]      occ_q, occ_d;
  logic            infl_q, infl_d;
  logic [SW-1:0]   slc_q, slc_d;
  logic [31:0]     req_q, req_d;
  logic [31:0]     word_q, word_d;
  logic            start_q, start_d;
  logic            bottom_q, bottom_d;
  logic            done_q, done_d;

  logic             out_valid, out_last, top, hs, free, last_hs, rd_en, clear;
  logic [OUT_W-1:0] out_data;

  // Head entry drives the stream directly; out_last flags the top slice of the last word.
  always_comb begin
    out_valid = (occ_q != 2'd0);
    top       = (slc_q == TOP);
    out_data  = ent0_q[int'(slc_q)*OUT_W +: OUT_W];
    out_last  = out_valid && (word_q == FRAME_WORDS - 32'd1) && top;
    hs        = out_valid && bus.out_ready;
    free      = hs && top;
    last_hs   = hs && out_last;
  end

  // Pops are suppressed on abort/frame_go so nothing new is in flight across a restart.
  always_comb begin
    rd_en = 1'b0;
    if (!abort && !frame_go && !bus.fifo_empty) begin
      unique case (state_q)
        S_FLUSH: rd_en = 1'b1;
        S_RUN:   rd_en = (({1'b0, occ_q} + {2'b00, infl_q}) < 3'd2) && (req_q < FRAME_WORDS);
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idle_d  = idle_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_d   = occ_q;
    slc_d   = slc_q;
    req_d   = req_q;
    word_d  = word_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    infl_d  = rd_en && (state_q == S_RUN);

    if (hs) slc_d = top ? '0 : slc_q + SW'(1);
    if (free) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
      if (word_q < FRAME_WORDS) word_d = word_q + 32'd1;
    end
    // Landing goes behind whatever survives this cycle's free.
    if (infl_q) begin
      if (occ_d == 2'd0) ent0_d = bus.dout;
      else               ent1_d = bus.dout;
      occ_d = occ_d + 2'd1;
    end
    if (infl_d && (req_q < FRAME_WORDS)) req_d = req_q + 32'd1;

    if (abort) begin
      state_d = S_IDLE;
      clear   = 1'b1;
    end else if (frame_go) begin
      state_d = S_REWIND;
      hold_d  = 8'd0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_REWIND: begin
          if (hold_q + 8'd1 >= BOTTOM_HOLD) begin
            state_d = S_FLUSH;
            idle_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        S_FLUSH: begin
          idle_d = bus.fifo_empty ? idle_q + 8'd1 : 8'd0;
          if (bus.fifo_empty && (idle_q + 8'd1 >= FLUSH_IDLE)) begin
            state_d = S_RUN;
            clear   = 1'b1;
          end
        end
        S_RUN: begin
          if (last_hs) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A landing word that arrives with a clear is an orphan of the old frame and is dropped.
    if (clear) begin
      occ_d  = 2'd0;
      slc_d  = '0;
      infl_d = 1'b0;
      req_d  = 32'd0;
      word_d = 32'd0;
    end

    start_d  = (state_d == S_RUN);
    bottom_d = (state_d == S_REWIND);
  end

  always_ff @(posedge rd_clk or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      hold_q   <= 8'd0;
      idle_q   <= 8'd0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      occ_q    <= 2'd0;
      infl_q   <= 1'b0;
      slc_q    <= '0;
      req_q    <= 32'd0;
      word_q   <= 32'd0;
      start_q  <= 1'b0;
      bottom_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      slc_q    <= slc_d;
      req_q    <= req_d;
      word_q   <= word_d;
      start_q  <= start_d;
      bottom_q <= bottom_d;
      done_q   <= done_d;
    end
  end

  assign start         = start_q;
  assign bottom        = bottom_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = done_q;
  assign bus.rd_en     = rd_en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_seq_stream_unpacker.sv
// Bench for seq_stream_unpacker: FIFO and reader model, table of frame scenarios,
// slice scoreboard built from the frame's byte ramp.
module tb_seq_stream_unpacker;
  localparam int OUT_W = 32;
  localparam int FW    = 4;
  localparam int NS    = 128 / OUT_W;
  localparam int BH    = 8;
  localparam int FI    = 32;

  logic rd_clk = 1'b0;
  logic RST = 1'b1;
  logic frame_go = 1'b0;
  logic abort = 1'b0;
  logic start, bottom, busy, frame_done;

  seq_stream_unpacker_if #(.OUT_W(OUT_W)) bus ();

  seq_stream_unpacker #(
    .OUT_W(OUT_W), .FRAME_WORDS(32'(FW)), .BOTTOM_HOLD(8'(BH)), .FLUSH_IDLE(8'(FI))
  ) dut (
    .rd_clk(rd_clk), .RST(RST), .frame_go(frame_go), .abort(abort),
    .start(start), .bottom(bottom), .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    string name;
    int    ready_pct;
    int    gap_pct;
    int    stale;
    int    inj;        // 0 none, 1 frame_go, 2 abort, 3 RST
    int    inj_at;
    int    exp_slices;
    int    exp_done;
    int    exp_pops;   // -1: not determined
  } row_t;

  row_t rows[10];

  int n_cmp = 0, n_fail = 0;
  logic [127:0]     fifo_q[$];
  logic [OUT_W-1:0] exp_q[$];
  bit pop_pend, loaded, prev_stall, last_hs_prev, prev_flush;
  logic [OUT_W-1:0] prev_data;
  int ready_pct, gap_pct, base;
  int acc, run_pops, flush_pops, bottom_cyc, empty_run, flush_run, done_cnt, stale_at_go;
  int err_empty, err_stable, err_occ, err_done, err_bs;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int b, input int i);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(b + 16*i + k);
    return w;
  endfunction

  task automatic new_frame();
    logic [OUT_W-1:0] e;
    exp_q.delete();
    for (int s = 0; s < FW*NS; s++) begin
      for (int k = 0; k < OUT_W/8; k++) e[8*k +: 8] = 8'(base + s*(OUT_W/8) + k);
      exp_q.push_back(e);
    end
    acc = 0; run_pops = 0; flush_pops = 0; bottom_cyc = 0; empty_run = 0;
    flush_run = -1; done_cnt = 0; prev_flush = 0; loaded = 0;
    stale_at_go = fifo_q.size();
  endtask

  task automatic observe();
    bit hs, fl;
    logic [OUT_W-1:0] e;
    hs = bus.out_valid && bus.out_ready;
    fl = busy && !bottom && !start;
    if (bus.rd_en && bus.fifo_empty) err_empty++;
    if (bottom && start) err_bs++;
    if (bottom) bottom_cyc++;
    if (fl) empty_run = bus.fifo_empty ? empty_run + 1 : 0;
    if (start && prev_flush) flush_run = empty_run;
    prev_flush = fl;
    if (bus.rd_en) begin
      pop_pend = 1;
      if (start) run_pops++;
      else if (fl) flush_pops++;
    end
    if (start && (run_pops - acc/NS) > 2) err_occ++;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) err_stable++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (frame_done) begin
      done_cnt++;
      if (!last_hs_prev) err_done++;
    end
    last_hs_prev = hs && bus.out_last;
    if (hs) begin
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("slice", 64'(bus.out_data), 64'(e));
      check("out_last", 64'(bus.out_last), 64'(exp_q.size() == 0));
      acc++;
    end
  endtask

  task automatic step(input bit go, input bit ab, input bit hold_ready);
    @(negedge rd_clk);
    if (pop_pend) begin
      if (fifo_q.size() > 0) bus.dout = fifo_q.pop_front();
      else err_empty++;
      pop_pend = 0;
    end
    if (start && !loaded) begin
      for (int i = 0; i < FW + 2; i++) fifo_q.push_back(mkword(base, i));
      loaded = 1;
    end
    frame_go = go;
    abort    = ab;
    if (go || ab) last_hs_prev = 0;
    if (go) new_frame();
    bus.fifo_empty = (fifo_q.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
    bus.out_ready  = !hold_ready && (int'($urandom_range(0, 99)) < ready_pct);
    #1;
    observe();
    if (go || ab) prev_stall = 0;
  endtask

  task automatic run_row(input row_t r, input int idx);
    bit injected, finished;
    int post;
    ready_pct = r.ready_pct;
    gap_pct   = r.gap_pct;
    err_empty = 0; err_stable = 0; err_occ = 0; err_done = 0; err_bs = 0;
    for (int i = 0; i < r.stale; i++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    base = (idx == 0) ? 0 : int'($urandom_range(1, 250));
    step(1, 0, 1);
    injected = 0; finished = 0; post = -1;
    for (int c = 0; c < 3000; c++) begin
      if (r.inj != 0 && !injected && start && acc == r.inj_at) begin
        injected = 1;
        case (r.inj)
          1: begin
            base = int'($urandom_range(1, 250));
            step(1, 0, 1);
          end
          2: step(0, 1, 1);
          default: begin
            step(0, 0, 1);
            RST = 1'b1;
            pop_pend = 0;
            #1;
            check({r.name, ".rst_start"},     64'(start),         64'd0);
            check({r.name, ".rst_bottom"},    64'(bottom),        64'd0);
            check({r.name, ".rst_rd_en"},     64'(bus.rd_en),     64'd0);
            check({r.name, ".rst_out_valid"}, 64'(bus.out_valid), 64'd0);
            check({r.name, ".rst_busy"},      64'(busy),          64'd0);
            check({r.name, ".rst_out_data"},  64'(bus.out_data),  64'd0);
            @(posedge rd_clk);
            #2 RST = 1'b0;
            prev_stall = 0; last_hs_prev = 0;
          end
        endcase
        continue;
      end
      if (post < 0 && ((r.inj <= 1 && done_cnt > 0) || (r.inj >= 2 && injected))) post = 0;
      if (post >= 0) begin
        if (post == 30) begin finished = 1; break; end
        post++;
      end
      step(0, 0, 0);
    end
    check({r.name, ".finished"},        64'(finished),    64'd1);
    check({r.name, ".slices"},          64'(acc),         64'(r.exp_slices));
    check({r.name, ".frame_done"},      64'(done_cnt),    64'(r.exp_done));
    check({r.name, ".bottom_cycles"},   64'(bottom_cyc),  64'(BH));
    check({r.name, ".flush_empty_run"}, 64'(flush_run),   64'(FI));
    check({r.name, ".stale_popped"},    64'(flush_pops),  64'(stale_at_go));
    check({r.name, ".busy_end"},        64'(busy),        64'd0);
    check({r.name, ".start_end"},       64'(start),       64'd0);
    check({r.name, ".rd_en_empty"},     64'(err_empty),   64'd0);
    check({r.name, ".data_stable"},     64'(err_stable),  64'd0);
    check({r.name, ".occupancy"},       64'(err_occ),     64'd0);
    check({r.name, ".done_timing"},     64'(err_done),    64'd0);
    check({r.name, ".bottom_vs_start"}, 64'(err_bs),      64'd0);
    if (r.exp_pops >= 0) begin
      check({r.name, ".run_pops"},     64'(run_pops),      64'(r.exp_pops));
      check({r.name, ".surplus_left"}, 64'(fifo_q.size()), 64'd2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{"basic",       100,  0, 0, 0, 0, 16, 1,  4};
    rows[1] = '{"backpress",    50,  0, 0, 0, 0, 16, 1,  4};
    rows[2] = '{"fifo_gaps",   100, 40, 0, 0, 0, 16, 1,  4};
    rows[3] = '{"flush_stale", 100,  0, 3, 0, 0, 16, 1,  4};
    rows[4] = '{"mixed",        60, 30, 1, 0, 0, 16, 1,  4};
    rows[5] = '{"restart",     100,  0, 0, 1, 5, 16, 1,  4};
    rows[6] = '{"restart_bp",   70, 20, 2, 1, 5, 16, 1,  4};
    rows[7] = '{"abort",       100,  0, 0, 2, 9,  9, 0, -1};
    rows[8] = '{"rst_mid",      80, 10, 0, 3, 9,  9, 0, -1};
    rows[9] = '{"recover",      50, 30, 0, 0, 0, 16, 1,  4};

    bus.dout = '0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b0;
    pop_pend = 0; loaded = 0; prev_stall = 0; last_hs_prev = 0; prev_flush = 0;
    prev_data = '0;

    for (int i = 0; i < 6; i++) begin
      @(negedge rd_clk);
      frame_go = 1'($urandom); abort = 1'($urandom);
      bus.fifo_empty = 1'($urandom); bus.out_ready = 1'($urandom);
      bus.dout = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("reset.start",      64'(start),         64'd0);
      check("reset.bottom",     64'(bottom),        64'd0);
      check("reset.rd_en",      64'(bus.rd_en),     64'd0);
      check("reset.out_valid",  64'(bus.out_valid), 64'd0);
      check("reset.busy",       64'(busy),          64'd0);
      check("reset.frame_done", 64'(frame_done),    64'd0);
    end
    @(negedge rd_clk);
    frame_go = 0; abort = 0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b0;
    RST = 1'b0;

    for (int i = 0; i < 10; i++) run_row(rows[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
